mem_bank_arbiter: RTL

Single-bank request arbiter for the memory island. It shares one SRAM bank port between `NumReq` memory-side requesters, such as AXI-adapter outputs and direct ports. Port 0 gets bounded priority; the other ports share grants round-robin. The block tracks every granted access through a fixed-latency pipeline so that each response returns to the port that issued it.

---
 rtl/mem_bank_arbiter_if.sv | 32 +++
 rtl/mem_bank_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/mem_bank_arbiter_if.sv
// Requester and bank-side signal bundle for mem_bank_arbiter.
// Signal names carry the arbiter's point of view (_i into the arbiter, _o out of it).
interface mem_bank_arbiter_if #(
   parameter int unsigned NumReq    = 4,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64
);
   logic [NumReq-1:0]               req_i;
   logic [NumReq*AddrWidth-1:0]     addr_i;
   logic [NumReq-1:0]               we_i;
   logic [NumReq*(DataWidth/8)-1:0] be_i;
   logic [NumReq*DataWidth-1:0]     wdata_i;
   logic [NumReq-1:0]               gnt_o;
   logic [NumReq-1:0]               rvalid_o;
   logic [DataWidth-1:0]            rdata_o;
   logic                            bank_req_o;
   logic [AddrWidth-1:0]            bank_addr_o;
   logic                            bank_we_o;
   logic [DataWidth/8-1:0]          bank_be_o;
   logic [DataWidth-1:0]            bank_wdata_o;
   logic [DataWidth-1:0]            bank_rdata_i;

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i, bank_rdata_i,
      output gnt_o, rvalid_o, rdata_o, bank_req_o, bank_addr_o, bank_we_o, bank_be_o, bank_wdata_o
   );

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i, bank_rdata_i,
      input  gnt_o, rvalid_o, rdata_o, bank_req_o, bank_addr_o, bank_we_o, bank_be_o, bank_wdata_o
   );
endinterface

// File: rtl/mem_bank_arbiter.sv
// Single-bank arbiter: bounded port-0 priority, round-robin among ports 1..NumReq-1,
// and a fixed-latency id pipeline that routes each response back to its issuing port.
module mem_bank_arbiter #(
   parameter int unsigned NumReq        = 4,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned BankLatency   = 1,
   parameter int unsigned MaxPrioGrants = 4
) (
   input logic               clk_i,
   input logic               rst_ni,
   mem_bank_arbiter_if.slave bus
);
   localparam int unsigned IdW  = $clog2(NumReq);
   localparam int unsigned CntW = $clog2(MaxPrioGrants + 1);
   localparam int unsigned BeW  = DataWidth / 8;

   logic [IdW-1:0]                  rr_q, rr_d;
   logic [CntW-1:0]                 prio_cnt_q, prio_cnt_d;
   logic [BankLatency-1:0]          vld_q;
   logic [BankLatency-1:0][IdW-1:0] id_q;

   logic           others, prio_win, any_req;
   logic [IdW-1:0] rr_win, win;
   int unsigned    idx;

   assign others   = |bus.req_i[NumReq-1:1];
   // Outputs are forced idle while reset is held, even with requests pending.
   assign any_req  = rst_ni & (|bus.req_i);
   assign prio_win = bus.req_i[0] & (~others | (prio_cnt_q < CntW'(MaxPrioGrants)));

   // Walk offsets from farthest to nearest so the nearest requester at or after rr_q wins.
   always_comb begin
      rr_win = rr_q;
      idx    = 0;
      for (int unsigned i = 0; i < NumReq - 1; i++) begin
         idx = ((NumReq - 2 - i) + 32'(rr_q) - 1) % (NumReq - 1) + 1;
         if (bus.req_i[idx]) rr_win = IdW'(idx);
      end
   end

   assign win = prio_win ? '0 : rr_win;

   always_comb begin
      bus.gnt_o        = '0;
      bus.bank_req_o   = 1'b0;
      bus.bank_addr_o  = '0;
      bus.bank_we_o    = 1'b0;
      bus.bank_be_o    = '0;
      bus.bank_wdata_o = '0;
      if (any_req) begin
         bus.gnt_o        = NumReq'(1) << win;
         bus.bank_req_o   = 1'b1;
         bus.bank_addr_o  = bus.addr_i[win*AddrWidth +: AddrWidth];
         bus.bank_we_o    = bus.we_i[win];
         bus.bank_be_o    = bus.be_i[win*BeW +: BeW];
         bus.bank_wdata_o = bus.wdata_i[win*DataWidth +: DataWidth];
      end
   end

   always_comb begin
      rr_d       = rr_q;
      prio_cnt_d = prio_cnt_q;
      if (any_req && (win != '0)) begin
         rr_d       = (win == IdW'(NumReq - 1)) ? IdW'(1) : win + IdW'(1);
         prio_cnt_d = '0;
      end else if (!others) begin
         prio_cnt_d = '0;
      end else if (any_req && (prio_cnt_q != CntW'(MaxPrioGrants))) begin
         prio_cnt_d = prio_cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= IdW'(1);
         prio_cnt_q <= '0;
         vld_q      <= '0;
         id_q       <= '0;
      end else begin
         rr_q       <= rr_d;
         prio_cnt_q <= prio_cnt_d;
         vld_q[0]   <= any_req;
         id_q[0]    <= win;
         for (int unsigned i = 1; i < BankLatency; i++) begin
            vld_q[i] <= vld_q[i-1];
            id_q[i]  <= id_q[i-1];
         end
      end
   end

   assign bus.rvalid_o = vld_q[BankLatency-1] ? (NumReq'(1) << id_q[BankLatency-1]) : '0;
   assign bus.rdata_o  = bus.bank_rdata_i;
endmodule
